// File: rtl/hud_digit_writer_if.sv
// Request/response bundle between the score logic and the digit writer,
// plus the registered digit-slot write bus that feeds the HUD display.
interface hud_digit_writer_if;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_value;
    logic [3:0]  req_base;
    logic [2:0]  req_width;
    logic        write;
    logic [3:0]  num;
    logic [3:0]  blob;
    logic        done;

    modport master (
        output req_valid, req_value, req_base, req_width,
        input  req_ready, write, num, blob, done
    );

    modport slave (
        input  req_valid, req_value, req_base, req_width,
        output req_ready, write, num, blob, done
    );
endinterface

// File: rtl/hud_digit_writer.sv
// Converts a binary value to decimal with a sequential double-dabble and
// streams the digits, most significant first, onto the HUD slot write bus.
module hud_digit_writer #(
    parameter int SLOTS = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    hud_digit_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] value_q, value_d;
    logic [27:0] bcd_q, bcd_d;
    logic [3:0]  base_q, base_d;
    logic [2:0]  width_q, width_d;
    logic [4:0]  iter_q, iter_d;
    logic [2:0]  k_q, k_d;
    logic        write_q, write_d;
    logic [3:0]  num_q, num_d;
    logic [3:0]  blob_q, blob_d;
    logic        done_q, done_d;

    logic [27:0] bcd_adj;
    logic [2:0]  digit_idx;
    logic [27:0] bcd_shifted;
    logic [4:0]  blob_sum;
    logic        saturate;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            value_q <= '0;
            bcd_q   <= '0;
            base_q  <= '0;
            width_q <= '0;
            iter_q  <= '0;
            k_q     <= '0;
            write_q <= 1'b0;
            num_q   <= '0;
            blob_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            bcd_q   <= bcd_d;
            base_q  <= base_d;
            width_q <= width_d;
            iter_q  <= iter_d;
            k_q     <= k_d;
            write_q <= write_d;
            num_q   <= num_d;
            blob_q  <= blob_d;
            done_q  <= done_d;
        end
    end

    // Any nonzero digit above the requested width means the value does not fit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 7; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        digit_idx   = width_q - 3'd1 - k_q;
        bcd_shifted = bcd_q >> {digit_idx, 2'b00};
        blob_sum    = {1'b0, base_q} + {2'b00, k_q};
        saturate    = (bcd_q >> {width_q, 2'b00}) != 28'd0;
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        bcd_d   = bcd_q;
        base_d  = base_q;
        width_d = width_q;
        iter_d  = iter_q;
        k_d     = k_q;
        write_d = 1'b0;
        num_d   = num_q;
        blob_d  = blob_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    value_d = bus.req_value;
                    base_d  = bus.req_base;
                    width_d = (bus.req_width == 3'd0) ? 3'd1 : bus.req_width;
                    bcd_d   = '0;
                    iter_d  = '0;
                    k_d     = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, value_d} = {bcd_adj, value_q} << 1;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd19) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // One extra cycle after the last digit carries the done pulse.
                if (k_q == width_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    write_d = (blob_sum <= 5'(SLOTS - 1));
                    num_d   = saturate ? 4'd9 : bcd_shifted[3:0];
                    blob_d  = blob_sum[3:0];
                    k_d     = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.write     = write_q;
    assign bus.num       = num_q;
    assign bus.blob      = blob_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_hud_digit_writer.sv
// Self-checking bench for hud_digit_writer: directed vector table, reset and
// back-to-back sequences, then random requests against an arithmetic model.
module tb_hud_digit_writer;

    localparam int SLOTS = 14;

    typedef struct packed {
        logic [19:0] value;
        logic [3:0]  base;
        logic [2:0]  width;
        logic [27:0] exp_nums;
        logic [6:0]  exp_mask;
        logic [2:0]  exp_w;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    hud_digit_writer_if bus();

    hud_digit_writer #(.SLOTS(SLOTS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic int pow10(input int e);
        int p;
        p = 1;
        for (int i = 0; i < e; i++) p = p * 10;
        return p;
    endfunction

    // Decimal digits straight from arithmetic: clamp to the width's limit, then divide.
    function automatic void model(input logic [19:0] value, input logic [2:0] width, input logic [3:0] base,
                                  output logic [27:0] nums, output logic [6:0] mask, output int w);
        int limit;
        int v;
        nums  = '0;
        mask  = '0;
        w     = (width == 3'd0) ? 1 : int'(width);
        limit = pow10(w) - 1;
        v     = (int'(value) > limit) ? limit : int'(value);
        for (int k = 0; k < w; k++) begin
            nums[4*k +: 4] = 4'((v / pow10(w - 1 - k)) % 10);
            mask[k]        = (int'(base) + k) <= (SLOTS - 1);
        end
    endfunction

    // Waits for ready, presents one request, returns just after the acceptance edge.
    task automatic apply_stimulus(input logic [19:0] value, input logic [3:0] base, input logic [2:0] width);
        int waited;
        waited = 0;
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_value = value;
        bus.req_base  = base;
        bus.req_width = width;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_value = 20'($urandom);
        bus.req_base  = 4'($urandom);
        bus.req_width = 3'($urandom);
    endtask

    // Checks every cycle from A+1 through the done edge A+21+w.
    task automatic check_output(input string tag, input logic [27:0] exp_nums, input logic [6:0] exp_mask,
                                input logic [3:0] base, input int w);
        int k;
        for (int n = 1; n <= 21 + w; n++) begin
            @(negedge clk);
            if (n <= 20) begin
                check($sformatf("%s busy n=%0d", tag, n), {29'd0, bus.write, bus.done, bus.req_ready}, 32'd0);
            end else if (n < 21 + w) begin
                k = n - 21;
                check($sformatf("%s write k=%0d", tag, k), {31'd0, bus.write}, {31'd0, exp_mask[k]});
                check($sformatf("%s done k=%0d", tag, k), {31'd0, bus.done}, 32'd0);
                if (exp_mask[k]) begin
                    check($sformatf("%s num k=%0d", tag, k), {28'd0, bus.num}, {28'd0, exp_nums[4*k +: 4]});
                    check($sformatf("%s blob k=%0d", tag, k), {28'd0, bus.blob}, 32'(int'(base) + k));
                end
            end else begin
                check($sformatf("%s done", tag), {31'd0, bus.done}, 32'd1);
                check($sformatf("%s ready", tag), {31'd0, bus.req_ready}, 32'd1);
                check($sformatf("%s write_end", tag), {31'd0, bus.write}, 32'd0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [9];
        logic [27:0] m_nums;
        logic [6:0]  m_mask;
        int          m_w;
        logic [19:0] r_value;
        logic [3:0]  r_base;
        logic [2:0]  r_width;
        int          mag;

        vecs[0] = '{20'd1234,    4'd0,  3'd4, 28'h0004321, 7'b0001111, 3'd4};
        vecs[1] = '{20'd12345,   4'd5,  3'd3, 28'h0000999, 7'b0000111, 3'd3};
        vecs[2] = '{20'd4321,    4'd12, 3'd4, 28'h0000034, 7'b0000011, 3'd4};
        vecs[3] = '{20'd7,       4'd9,  3'd0, 28'h0000007, 7'b0000001, 3'd1};
        vecs[4] = '{20'd1048575, 4'd7,  3'd7, 28'h5758401, 7'b1111111, 3'd7};
        vecs[5] = '{20'd0,       4'd0,  3'd5, 28'h0000000, 7'b0011111, 3'd5};
        vecs[6] = '{20'd99999,   4'd0,  3'd5, 28'h0099999, 7'b0011111, 3'd5};
        vecs[7] = '{20'd100000,  4'd8,  3'd5, 28'h0099999, 7'b0011111, 3'd5};
        vecs[8] = '{20'd999999,  4'd9,  3'd6, 28'h0999999, 7'b0011111, 3'd6};

        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_value = '0;
        bus.req_base  = '0;
        bus.req_width = '0;
        repeat (3) @(negedge clk);
        check("reset write", {31'd0, bus.write}, 32'd0);
        check("reset num", {28'd0, bus.num}, 32'd0);
        check("reset blob", {28'd0, bus.blob}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset ready", {31'd0, bus.req_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].value, vecs[i].base, vecs[i].width);
            check_output($sformatf("vec%0d", i), vecs[i].exp_nums, vecs[i].exp_mask,
                         vecs[i].base, int'(vecs[i].exp_w));
        end
        @(negedge clk);
        check("done single cycle", {31'd0, bus.done}, 32'd0);

        // Reset lands right after the second digit of a 4-digit request.
        apply_stimulus(20'd1234, 4'd0, 3'd4);
        for (int n = 1; n <= 22; n++) @(negedge clk);
        check("pre_reset write", {31'd0, bus.write}, 32'd1);
        check("pre_reset num", {28'd0, bus.num}, 32'd2);
        check("pre_reset blob", {28'd0, bus.blob}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_reset write", {31'd0, bus.write}, 32'd0);
        check("mid_reset num", {28'd0, bus.num}, 32'd0);
        check("mid_reset blob", {28'd0, bus.blob}, 32'd0);
        check("mid_reset done", {31'd0, bus.done}, 32'd0);
        check("mid_reset ready", {31'd0, bus.req_ready}, 32'd1);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("held_reset write n=%0d", n), {31'd0, bus.write}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset ready", {31'd0, bus.req_ready}, 32'd1);
        apply_stimulus(20'd56, 4'd0, 3'd2);
        check_output("post_reset", 28'h0000065, 7'b0000011, 4'd0, 2);

        // Valid held high: second request rides in at A+24 while inputs change mid-flight.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_value = 20'd11;
        bus.req_base  = 4'd0;
        bus.req_width = 3'd2;
        @(posedge clk);
        @(negedge clk);
        bus.req_value = 20'd22;
        bus.req_base  = 4'd2;
        bus.req_width = 3'd2;
        check_output("b2b_first", 28'h0000011, 7'b0000011, 4'd0, 2);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_value = 20'($urandom);
        check_output("b2b_second", 28'h0000022, 7'b0000011, 4'd2, 2);

        for (int r = 0; r < 40; r++) begin
            r_width = 3'($urandom_range(0, 7));
            r_base  = 4'($urandom_range(0, 15));
            mag     = pow10(int'($urandom_range(1, 7)));
            r_value = (mag > 1048575) ? 20'($urandom_range(0, 1048575))
                                      : 20'($urandom_range(0, mag));
            model(r_value, r_width, r_base, m_nums, m_mask, m_w);
            apply_stimulus(r_value, r_base, r_width);
            check_output($sformatf("rand%0d v=%0d b=%0d w=%0d", r, r_value, r_base, r_width),
                         m_nums, m_mask, r_base, m_w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
